// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit pipelined processor.
// Holds the datapath and register-index widths, the memory-stage
// state encoding, and the default memory-mapped I/O address.
// The decode stage uses the same I/O address constant.
package proc_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 3;

  // Default address of the memory-mapped I/O port.
  localparam logic [DATA_W-1:0] IO_ADDR_DEFAULT = 8'hFF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// Data RAM for the memory-access stage.
// DEPTH words of DATA_W bits, one synchronous write port and one
// asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module dm_ram
  import proc_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; a reset term would turn it into a
  // flop bank. It is zeroed instead by the clear sweep in the parent.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access (DM) stage of the 8-bit pipelined processor.
// Performs loads and stores against a local data RAM and one
// memory-mapped I/O location. It registers the ALU result or the load
// data for Write_Back. After reset, a sweep writes zero to every RAM
// word. dm_ready is held low until the sweep is finished.
//   clk, reset                : clock, synchronous active-high reset
//   valid_ex .. dest_reg_ex   : instruction from Execute
//   io_in                     : external input, read at IO_ADDR
//   dm_ready                  : stage can accept (RUN state)
//   mux_ans_dm .. valid_dm    : registered results to Write_Back
//   io_out                    : memory-mapped output register
module data_mem_stage
  import proc_pkg::*;
#(
  parameter int                DEPTH   = 32,
  parameter int                ADDR_W  = 5,
  parameter logic [DATA_W-1:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_ex,
  input  logic [DATA_W-1:0]    alu_ans_ex,
  input  logic [DATA_W-1:0]    store_data_ex,
  input  logic                 mem_rd_ex,
  input  logic                 mem_wr_ex,
  input  logic                 reg_wr_ex,
  input  logic [REG_IDX_W-1:0] dest_reg_ex,
  input  logic [DATA_W-1:0]    io_in,
  output logic                 dm_ready,
  output logic [DATA_W-1:0]    mux_ans_dm,
  output logic                 reg_wr_dm,
  output logic [REG_IDX_W-1:0] dest_reg_dm,
  output logic                 valid_dm,
  output logic [DATA_W-1:0]    io_out
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  dm_state_e            state_q, state_d;
  logic [ADDR_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]    mux_ans_q, mux_ans_d;
  logic                 reg_wr_q, reg_wr_d;
  logic [REG_IDX_W-1:0] dest_reg_q, dest_reg_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    io_out_q, io_out_d;

  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;

  logic                 is_io;
  logic                 in_ram;

  // The range check uses the full 8-bit address. The value is truncated
  // to a RAM index only after the check passes.
  assign is_io  = (alu_ans_ex == IO_ADDR);
  assign in_ram = ({1'b0, alu_ans_ex} < 9'(DEPTH));

  // NOTE: every signal gets a default at the top of the block, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    mux_ans_d  = mux_ans_q;
    reg_wr_d   = 1'b0;
    dest_reg_d = dest_reg_q;
    valid_d    = 1'b0;
    io_out_d   = io_out_q;
    ram_we     = 1'b0;
    ram_waddr  = clr_ptr_q;
    ram_wdata  = '0;

    unique case (state_q)
      CLEAR: begin
        // The sweep shares the single RAM write port and ignores Execute.
        ram_we = 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = RUN;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (valid_ex) begin
          valid_d    = 1'b1;
          reg_wr_d   = reg_wr_ex;
          dest_reg_d = dest_reg_ex;
          if (mem_wr_ex) begin
            // A store has priority over a load when both flags are set.
            mux_ans_d = alu_ans_ex;
            if (is_io) begin
              io_out_d = store_data_ex;
            end else if (in_ram) begin
              ram_we    = 1'b1;
              ram_waddr = alu_ans_ex[ADDR_W-1:0];
              ram_wdata = store_data_ex;
            end
          end else if (mem_rd_ex) begin
            if (is_io) begin
              mux_ans_d = io_in;
            end else if (in_ram) begin
              mux_ans_d = ram_rdata;
            end else begin
              mux_ans_d = '0;
            end
          end else begin
            mux_ans_d = alu_ans_ex;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      mux_ans_q  <= '0;
      reg_wr_q   <= 1'b0;
      dest_reg_q <= '0;
      valid_q    <= 1'b0;
      io_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      mux_ans_q  <= mux_ans_d;
      reg_wr_q   <= reg_wr_d;
      dest_reg_q <= dest_reg_d;
      valid_q    <= valid_d;
      io_out_q   <= io_out_d;
    end
  end

  // A store that arrives together with reset must not reach the RAM.
  dm_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && !reset),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (alu_ans_ex[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign dm_ready    = (state_q == RUN);
  assign mux_ans_dm  = mux_ans_q;
  assign reg_wr_dm   = reg_wr_q;
  assign dest_reg_dm = dest_reg_q;
  assign valid_dm    = valid_q;
  assign io_out      = io_out_q;

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

  localparam int         DEPTH = 32;
  localparam logic [7:0] IO_A  = 8'hFF;

  logic       clk;
  logic       reset;
  logic       valid_ex;
  logic [7:0] alu_ans_ex;
  logic [7:0] store_data_ex;
  logic       mem_rd_ex;
  logic       mem_wr_ex;
  logic       reg_wr_ex;
  logic [2:0] dest_reg_ex;
  logic [7:0] io_in;
  logic       dm_ready;
  logic [7:0] mux_ans_dm;
  logic       reg_wr_dm;
  logic [2:0] dest_reg_dm;
  logic       valid_dm;
  logic [7:0] io_out;

  int checks = 0;
  int errors = 0;

  data_mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .valid_ex      (valid_ex),
    .alu_ans_ex    (alu_ans_ex),
    .store_data_ex (store_data_ex),
    .mem_rd_ex     (mem_rd_ex),
    .mem_wr_ex     (mem_wr_ex),
    .reg_wr_ex     (reg_wr_ex),
    .dest_reg_ex   (dest_reg_ex),
    .io_in         (io_in),
    .dm_ready      (dm_ready),
    .mux_ans_dm    (mux_ans_dm),
    .reg_wr_dm     (reg_wr_dm),
    .dest_reg_dm   (dest_reg_dm),
    .valid_dm      (valid_dm),
    .io_out        (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and samples the outputs 1 ns after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] a,
                      input logic [7:0] sd, input logic rd, input logic wr,
                      input logic rw, input logic [2:0] d, input logic [7:0] ii);
    reset = r; valid_ex = v; alu_ans_ex = a; store_data_ex = sd;
    mem_rd_ex = rd; mem_wr_ex = wr; reg_wr_ex = rw; dest_reg_ex = d; io_in = ii;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // Counts not-ready cycles after a reset release. It also checks that
  // valid_dm stays low. The loop is bounded.
  task automatic sweep_check(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (!dm_ready && n < 200) begin
      if (valid_dm !== 1'b0 || reg_wr_dm !== 1'b0) bad++;
      idle();
      n++;
    end
    check({tag, "_len"}, n, DEPTH);
    check({tag, "_valid_low"}, bad, 0);
    check({tag, "_ready_after"}, int'(dm_ready), 1);
  endtask

  // Reference model of the stage: architectural state and the expected
  // registered outputs.
  logic [7:0] m_ram [DEPTH];
  logic [7:0] m_io, m_mux;
  logic [2:0] m_dest;
  logic       m_valid, m_regwr;
  int         m_clear_left;

  task automatic model_step(input logic r, input logic v, input logic [7:0] a,
                            input logic [7:0] sd, input logic rd, input logic wr,
                            input logic rw, input logic [2:0] d, input logic [7:0] ii);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_ram[i] = 8'h00;
      m_io = 8'h00; m_mux = 8'h00; m_dest = 3'd0; m_valid = 1'b0; m_regwr = 1'b0;
      m_clear_left = DEPTH;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      m_valid = 1'b0; m_regwr = 1'b0;
    end else if (!v) begin
      m_valid = 1'b0; m_regwr = 1'b0;
    end else begin
      m_valid = 1'b1; m_regwr = rw; m_dest = d;
      if (wr) begin
        if (a == IO_A) m_io = sd;
        else if (int'(a) < DEPTH) m_ram[int'(a)] = sd;
        m_mux = a;
      end else if (rd) begin
        if (a == IO_A) m_mux = ii;
        else if (int'(a) < DEPTH) m_mux = m_ram[int'(a)];
        else m_mux = 8'h00;
      end else begin
        m_mux = a;
      end
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] sd;
    logic       rd;
    logic       wr;
    logic       rw;
    logic [2:0] d;
    logic [7:0] ii;
    logic [7:0] e_mux;
    logic       e_valid;
    logic       e_regwr;
    logic [2:0] e_dest;
    logic [7:0] e_io;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // v, addr, sdata, rd, wr, rw, dest, io_in | mux, valid, regwr, dest, io_out
    tbl[0]  = '{1'b1, 8'h07, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h07, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{1'b1, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'h00, 8'hA5, 1'b1, 1'b1, 3'd2, 8'h00};
    tbl[2]  = '{1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 8'h3C, 1'b1, 1'b1, 3'd5, 8'h00};
    tbl[3]  = '{1'b0, 8'h07, 8'h77, 1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 8'h3C, 1'b0, 1'b0, 3'd5, 8'h00};
    tbl[4]  = '{1'b1, 8'hFF, 8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h5A};
    tbl[5]  = '{1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'hC3, 8'hC3, 1'b1, 1'b1, 3'd1, 8'h5A};
    tbl[6]  = '{1'b1, 8'h1F, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h5A};
    tbl[7]  = '{1'b1, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 8'hA5, 1'b1, 1'b1, 3'd3, 8'h5A};
    tbl[8]  = '{1'b1, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h5A};
    tbl[9]  = '{1'b1, 8'h40, 8'h77, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h40, 1'b1, 1'b0, 3'd0, 8'h5A};
    tbl[10] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h5A};
    tbl[11] = '{1'b1, 8'h08, 8'h99, 1'b1, 1'b1, 1'b1, 3'd4, 8'h00, 8'h08, 1'b1, 1'b1, 3'd4, 8'h5A};
    tbl[12] = '{1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 8'h99, 1'b1, 1'b0, 3'd6, 8'h5A};
    tbl[13] = '{1'b1, 8'h48, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h5A};

    // Reset and the initial clear sweep.
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check("rst_ready", int'(dm_ready), 0);
    check("rst_valid", int'(valid_dm), 0);
    check("rst_regwr", int'(reg_wr_dm), 0);
    check("rst_mux", int'(mux_ans_dm), 0);
    check("rst_dest", int'(dest_reg_dm), 0);
    check("rst_io", int'(io_out), 0);
    sweep_check("sweep0");

    // After the sweep, every RAM word reads as zero.
    begin
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b0, 1'b1, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        if (mux_ans_dm !== 8'h00 || valid_dm !== 1'b1) bad++;
      end
      check("cleared_ram_reads", bad, 0);
    end

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      step(1'b0, tbl[i].v, tbl[i].a, tbl[i].sd, tbl[i].rd, tbl[i].wr,
           tbl[i].rw, tbl[i].d, tbl[i].ii);
      check($sformatf("vec%0d_mux", i), int'(mux_ans_dm), int'(tbl[i].e_mux));
      check($sformatf("vec%0d_valid", i), int'(valid_dm), int'(tbl[i].e_valid));
      check($sformatf("vec%0d_regwr", i), int'(reg_wr_dm), int'(tbl[i].e_regwr));
      check($sformatf("vec%0d_dest", i), int'(dest_reg_dm), int'(tbl[i].e_dest));
      check($sformatf("vec%0d_io", i), int'(io_out), int'(tbl[i].e_io));
      check($sformatf("vec%0d_ready", i), int'(dm_ready), 1);
    end

    // Reset in mid-operation. A second reset during the sweep restarts it.
    step(1'b0, 1'b1, 8'h03, 8'h11, 1'b0, 1'b1, 1'b1, 3'd6, 8'h00);
    check("mid_store_valid", int'(valid_dm), 1);
    step(1'b1, 1'b1, 8'h04, 8'h22, 1'b0, 1'b1, 1'b1, 3'd6, 8'h00);
    check("mid_rst_io", int'(io_out), 0);
    check("mid_rst_mux", int'(mux_ans_dm), 0);
    check("mid_rst_dest", int'(dest_reg_dm), 0);
    check("mid_rst_valid", int'(valid_dm), 0);
    check("mid_rst_regwr", int'(reg_wr_dm), 0);
    check("mid_rst_ready", int'(dm_ready), 0);
    for (int i = 0; i < 10; i++) idle();
    check("mid_sweep_busy", int'(dm_ready), 0);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check("mid_rst2_ready", int'(dm_ready), 0);
    sweep_check("sweep_restart");
    step(1'b0, 1'b1, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00);
    check("mid_load3", int'(mux_ans_dm), 0);
    step(1'b0, 1'b1, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00);
    check("mid_load4", int'(mux_ans_dm), 0);

    // Randomized traffic compared against the model, starting from reset.
    begin
      logic       r, v, rd, wr, rw;
      logic [7:0] a, sd, ii;
      logic [2:0] d;
      int         sel;
      for (int i = 0; i < 600; i++) begin
        r   = (i == 0) || ($urandom_range(0, 149) == 0);
        v   = !r && (m_clear_left == 0) && ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        a   = (sel < 7) ? 8'($urandom_range(0, DEPTH - 1)) :
              (sel == 7) ? IO_A : 8'($urandom_range(0, 255));
        sd  = 8'($urandom_range(0, 255));
        ii  = 8'($urandom_range(0, 255));
        rd  = 1'($urandom_range(0, 1));
        wr  = 1'($urandom_range(0, 1));
        rw  = 1'($urandom_range(0, 1));
        d   = 3'($urandom_range(0, 7));
        model_step(r, v, a, sd, rd, wr, rw, d, ii);
        step(r, v, a, sd, rd, wr, rw, d, ii);
        check("rnd_ready", int'(dm_ready), int'(m_clear_left == 0));
        check("rnd_mux", int'(mux_ans_dm), int'(m_mux));
        check("rnd_valid", int'(valid_dm), int'(m_valid));
        check("rnd_regwr", int'(reg_wr_dm), int'(m_regwr));
        check("rnd_dest", int'(dest_reg_dm), int'(m_dest));
        check("rnd_io", int'(io_out), int'(m_io));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
